// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencing FSM and the datapath/memory.
// The master side is the controller: it reads the opcode and the memory
// handshake and drives every select, enable and strobe.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch_en;
    logic       reg_write;
    logic       mem_write;
    logic       mem_req;
    logic       illegal_instr;
    logic       mem_timeout;

    modport master (
        input  op, mem_ready,
        output alu_op, alu_src_a, alu_src_b, result_src, adr_src,
               ir_write, pc_update, branch_en, reg_write, mem_write,
               mem_req, illegal_instr, mem_timeout
    );

    modport slave (
        output op, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, result_src, adr_src,
               ir_write, pc_update, branch_en, reg_write, mem_write,
               mem_req, illegal_instr, mem_timeout
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multicycle RISC-V core: fetch, decode, execute,
// memory and writeback, with a bounded wait on the memory handshake.
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN adds the instret and cycles
// performance counters; without it the ports are absent and behaviour is unchanged.
module multicycle_ctrl #(
    parameter int STALL_MAX = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    multicycle_ctrl_if.master  bus
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]        instret,
    output logic [31:0]        cycles
`endif
);

    localparam int CNT_W = $clog2(STALL_MAX + 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch_en;
        logic       reg_write;
        logic       mem_write;
        logic       mem_req;
        logic       illegal_instr;
        logic       mem_timeout;
    } ctrl_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    ctrl_t            ctrl;
    ctrl_t            ctrl_out;
    logic             in_mem_state;
    logic             stall_hit;
    logic             retire;

    // A wait that would bring the count up to STALL_MAX abandons the access;
    // mem_ready on that same cycle wins because stall_hit needs it low.
    assign in_mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    assign stall_hit    = in_mem_state && !bus.mem_ready &&
                          (wait_cnt == CNT_W'(STALL_MAX - 1));

    // Moore output decode and next-state selection from the current state.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        ctrl       = '0;
        next_state = state;
        unique case (state)
            FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                if (bus.mem_ready) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_update = 1'b1;
                    next_state     = DECODE;
                end
            end
            DECODE: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECR;
                    OP_ITYPE:          next_state = EXECI;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    default: begin
                        ctrl.illegal_instr = 1'b1;
                        next_state         = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                next_state     = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
                if (bus.mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                ctrl.result_src = 2'b01;
                ctrl.reg_write  = 1'b1;
                next_state      = FETCH;
            end
            MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                if (bus.mem_ready) next_state = FETCH;
            end
            EXECR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_op    = 2'b10;
                next_state     = ALUWB;
            end
            EXECI: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = 2'b10;
                next_state     = ALUWB;
            end
            ALUWB: begin
                ctrl.reg_write = 1'b1;
                next_state     = FETCH;
            end
            BRANCH: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_op    = 2'b01;
                ctrl.branch_en = 1'b1;
                next_state     = FETCH;
            end
            JAL: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
                ctrl.pc_update = 1'b1;
                next_state     = ALUWB;
            end
            default: next_state = FETCH;
        endcase
        if (stall_hit) begin
            ctrl.mem_timeout = 1'b1;
            next_state       = FETCH;
        end
    end

    // Strobes and selects drop the moment reset asserts, even though the
    // state register already sits in FETCH.
    assign ctrl_out = reset_n ? ctrl : '0;

    assign bus.alu_op        = ctrl_out.alu_op;
    assign bus.alu_src_a     = ctrl_out.alu_src_a;
    assign bus.alu_src_b     = ctrl_out.alu_src_b;
    assign bus.result_src    = ctrl_out.result_src;
    assign bus.adr_src       = ctrl_out.adr_src;
    assign bus.ir_write      = ctrl_out.ir_write;
    assign bus.pc_update     = ctrl_out.pc_update;
    assign bus.branch_en     = ctrl_out.branch_en;
    assign bus.reg_write     = ctrl_out.reg_write;
    assign bus.mem_write     = ctrl_out.mem_write;
    assign bus.mem_req       = ctrl_out.mem_req;
    assign bus.illegal_instr = ctrl_out.illegal_instr;
    assign bus.mem_timeout   = ctrl_out.mem_timeout;

    // An instruction retires when it returns to FETCH after completing its work.
    assign retire = (next_state == FETCH) &&
                    ((state == MEMWB) || (state == ALUWB) || (state == BRANCH) ||
                     ((state == MEMWRITE) && bus.mem_ready));

    // State register, wait counter and optional performance counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
`ifdef MULTICYCLE_CTRL_PERF_EN
            instret  <= '0;
            cycles   <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= next_state;
            if (stall_hit || (next_state != state)) begin
                wait_cnt <= '0;
            end else if (in_mem_state && !bus.mem_ready &&
                         (wait_cnt != CNT_W'(STALL_MAX))) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
`ifdef MULTICYCLE_CTRL_PERF_EN
            cycles <= cycles + 32'd1;
            if (retire) instret <= instret + 32'd1;
`endif
        end
    end

`ifndef MULTICYCLE_CTRL_PERF_EN
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction sequences plus
// randomized opcodes and memory wait lengths, each instruction expanded by a
// reference model into its expected per-cycle control word.
module tb_multicycle_ctrl;

    localparam int STALL_MAX = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    multicycle_ctrl_if bus ();

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instret;
    logic [31:0] cycles;
    int unsigned exp_instret = 0;
    int unsigned exp_cycles  = 0;
`endif

    multicycle_ctrl #(.STALL_MAX(STALL_MAX)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .instret (instret),
        .cycles  (cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch_en;
        logic       reg_write;
        logic       mem_write;
        logic       mem_req;
        logic       illegal_instr;
        logic       mem_timeout;
    } word_t;

    typedef struct {
        logic [6:0] op;
        logic       ready;
        logic       retire;
        word_t      w;
        string      tag;
    } step_t;

    step_t plan[$];
    int    checks = 0;
    int    errors = 0;

    function automatic word_t observed();
        word_t o;
        o.alu_op        = bus.alu_op;
        o.alu_src_a     = bus.alu_src_a;
        o.alu_src_b     = bus.alu_src_b;
        o.result_src    = bus.result_src;
        o.adr_src       = bus.adr_src;
        o.ir_write      = bus.ir_write;
        o.pc_update     = bus.pc_update;
        o.branch_en     = bus.branch_en;
        o.reg_write     = bus.reg_write;
        o.mem_write     = bus.mem_write;
        o.mem_req       = bus.mem_req;
        o.illegal_instr = bus.illegal_instr;
        o.mem_timeout   = bus.mem_timeout;
        return o;
    endfunction

    task automatic push(input logic [6:0] op, input logic ready, input logic retire,
                        input word_t w, input string tag);
        step_t s;
        s.op = op; s.ready = ready; s.retire = retire; s.w = w; s.tag = tag;
        plan.push_back(s);
    endtask

    // Memory-phase control word: kind 0 = instruction fetch, 1 = load, 2 = store.
    function automatic word_t mem_word(input int kind, input logic ready, input logic to);
        word_t w = '0;
        w.mem_req     = 1'b1;
        w.mem_timeout = to;
        if (kind == 0) begin
            w.alu_src_b  = 2'b10;
            w.result_src = 2'b10;
            w.ir_write   = ready;
            w.pc_update  = ready;
        end else begin
            w.adr_src   = 1'b1;
            w.mem_write = (kind == 2);
        end
        return w;
    endfunction

    // A wait of STALL_MAX or more low cycles is abandoned on the STALL_MAX-th cycle.
    task automatic push_mem(input logic [6:0] op, input int kind, input int wait_cycles,
                            input logic retire_on_done, input string tag, output bit done);
        if (wait_cycles >= STALL_MAX) begin
            for (int i = 1; i <= STALL_MAX; i++)
                push(op, 1'b0, 1'b0, mem_word(kind, 1'b0, i == STALL_MAX), tag);
            done = 1'b0;
        end else begin
            for (int i = 0; i < wait_cycles; i++)
                push(op, 1'b0, 1'b0, mem_word(kind, 1'b0, 1'b0), tag);
            push(op, 1'b1, retire_on_done, mem_word(kind, 1'b1, 1'b0), tag);
            done = 1'b1;
        end
    endtask

    // Reference model: the cycle sequence an instruction walks through.
    task automatic plan_instr(input logic [6:0] op, input int fetch_wait, input int mem_wait);
        bit    done;
        word_t w;
        push_mem(op, 0, fetch_wait, 1'b0, "fetch", done);
        if (!done) return;
        w = '0; w.alu_src_a = 2'b01; w.alu_src_b = 2'b01;
        case (op)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111: ;
            default: w.illegal_instr = 1'b1;
        endcase
        push(op, 1'b1, 1'b0, w, "decode");
        case (op)
            7'b0000011, 7'b0100011: begin
                w = '0; w.alu_src_a = 2'b10; w.alu_src_b = 2'b01;
                push(op, 1'b1, 1'b0, w, "memadr");
                if (op == 7'b0000011) begin
                    push_mem(op, 1, mem_wait, 1'b0, "memread", done);
                    if (done) begin
                        w = '0; w.result_src = 2'b01; w.reg_write = 1'b1;
                        push(op, 1'b1, 1'b1, w, "memwb");
                    end
                end else begin
                    push_mem(op, 2, mem_wait, 1'b1, "memwrite", done);
                end
            end
            7'b0110011, 7'b0010011: begin
                w = '0; w.alu_src_a = 2'b10; w.alu_op = 2'b10;
                w.alu_src_b = (op == 7'b0010011) ? 2'b01 : 2'b00;
                push(op, 1'b1, 1'b0, w, "exec");
                w = '0; w.reg_write = 1'b1;
                push(op, 1'b1, 1'b1, w, "aluwb");
            end
            7'b1100011: begin
                w = '0; w.alu_src_a = 2'b10; w.alu_op = 2'b01; w.branch_en = 1'b1;
                push(op, 1'b1, 1'b1, w, "branch");
            end
            7'b1101111: begin
                w = '0; w.alu_src_a = 2'b01; w.alu_src_b = 2'b10; w.pc_update = 1'b1;
                push(op, 1'b1, 1'b0, w, "jal");
                w = '0; w.reg_write = 1'b1;
                push(op, 1'b1, 1'b1, w, "aluwb");
            end
            default: ;
        endcase
    endtask

    task automatic check_word(input string tag, input word_t exp);
        word_t obs;
        obs = observed();
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Plays planned cycles: drive just after the edge, check, advance a clock.
    task automatic run(input int max_steps);
        int n = 0;
        while (plan.size() > 0 && (max_steps < 0 || n < max_steps)) begin
            step_t s;
            s = plan.pop_front();
            bus.op        = s.op;
            bus.mem_ready = s.ready;
            #1;
            check_word(s.tag, s.w);
`ifdef MULTICYCLE_CTRL_PERF_EN
            checks++;
            assert (instret === exp_instret && cycles === exp_cycles)
            else begin
                errors++;
                $error("FAIL perf observed=%0d/%0d expected=%0d/%0d",
                       instret, cycles, exp_instret, exp_cycles);
            end
`endif
            @(posedge clk);
            #1;
`ifdef MULTICYCLE_CTRL_PERF_EN
            exp_cycles++;
            if (s.retire) exp_instret++;
`endif
            n++;
        end
    endtask

    function automatic int rand_wait();
        int r = $urandom_range(0, 19);
        if (r < 14) return r % 3;
        if (r < 17) return STALL_MAX - 1;
        return STALL_MAX + (r - 17);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] legal_ops [6];
        legal_ops[0] = 7'b0000011; legal_ops[1] = 7'b0100011; legal_ops[2] = 7'b0110011;
        legal_ops[3] = 7'b0010011; legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b1101111;

        // Reset: all enables, strobes and selects are zero even with mem_ready high.
        bus.op        = 7'b0110011;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_word("reset", '0);
        reset_n = 1'b1;

        // Directed sequences from the test plan.
        plan_instr(7'b0110011, 0, 0);            // add: 4 cycles
        plan_instr(7'b0000011, 0, 3);            // load with 3 wait states
        plan_instr(7'b1100011, 0, 0);            // branch
        plan_instr(7'b1101111, 0, 0);            // jal
        plan_instr(7'b0000000, 0, 0);            // illegal opcode
        plan_instr(7'b0100011, 0, STALL_MAX);    // store times out
        plan_instr(7'b0100011, 0, STALL_MAX - 1);// ready on the last allowed cycle
        plan_instr(7'b0110011, STALL_MAX, 0);    // fetch times out
        plan_instr(7'b0010011, 1, 0);            // I-type with fetch wait
        plan_instr(7'b0100011, 2, 0);            // store completes
        run(-1);

        // Reset in the middle of a store: strobes drop immediately, restart in FETCH.
        plan_instr(7'b0100011, 0, 5);
        run(4);
        reset_n = 1'b0;
        #1;
        check_word("midreset", '0);
        plan.delete();
        @(posedge clk);
        #1;
        check_word("midreset_hold", '0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        exp_instret = 0;
        exp_cycles  = 0;
`endif
        reset_n = 1'b1;
        plan_instr(7'b0110011, 0, 0);
        run(-1);

        // Randomized instruction stream.
        repeat (150) begin
            logic [6:0] op;
            if ($urandom_range(0, 7) == 0) op = 7'($urandom());
            else op = legal_ops[$urandom_range(0, 5)];
            plan_instr(op, rand_wait(), rand_wait());
            run(-1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main sequencing FSM for the multicycle variant of the RISC-V core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the shared ALU by issuing ALUOp (consumed by aludec) and the operand-mux selects. It also drives the register/memory write enables and the memory request handshake toward the unified instruction/data memory.

Parameters:
- STALL_MAX, 15: maximum wait cycles on mem_ready before mem_timeout fires; counter width is $clog2(STALL_MAX+1).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- op  in  7  instruction opcode, from the IR
- mem_ready  in  1  memory has completed the current request this cycle
- alu_op  out  2  to aludec: 00 add, 01 branch compare, 10 funct-decoded
- alu_src_a  out  2  00 PC, 01 OldPC, 10 register A
- alu_src_b  out  2  00 register WriteData, 01 ImmExt, 10 constant 4
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- adr_src  out  1  0 PC, 1 Result
- ir_write  out  1  latch IR and OldPC
- pc_update  out  1  unconditional PC write
- branch_en  out  1  qualifies aludec Branch[3:0] with flags for a conditional PC write
- reg_write  out  1  register file write
- mem_write  out  1  memory write strobe
- mem_req  out  1  memory access in progress
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode
- mem_timeout  out  1  one-cycle pulse when a wait exceeds STALL_MAX

Behaviour:
- Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
- Outputs are combinational from the state, except ir_write and pc_update in FETCH, which are gated by mem_ready.
- Reset: state = FETCH and wait counter = 0. While reset_n is low, every enable and strobe output is 0 and all selects are 00.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - Stays in FETCH until mem_ready=1.
  - On the mem_ready cycle: ir_write=1 and pc_update=1, then go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target computation).
  - op 0000011 or 0100011 -> MEMADR
  - op 0110011 -> EXECR
  - op 0010011 -> EXECI
  - op 1100011 -> BRANCH
  - op 1101111 -> JAL
  - any other op -> FETCH, with illegal_instr=1 for that cycle.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Holds until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, adr_src=1, result_src=00, mem_write=1 on every cycle until mem_ready, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch_en=1, then FETCH.
  - The beq/bne/blt/bge selection is made by aludec from funct3; this block never decodes funct3.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1, then ALUWB.
- Wait counter:
  - Cleared on entry to any memory state (FETCH, MEMREAD, MEMWRITE).
  - Increments each cycle the FSM is in a memory state with mem_ready=0, and saturates at STALL_MAX.
  - On the cycle the count reaches STALL_MAX, mem_timeout pulses once and the FSM returns to FETCH, abandoning the access.
  - mem_ready=1 on that same cycle takes priority: normal transition, no pulse.
- Asynchronous reset mid-instruction: the FSM is forced to FETCH immediately and strobes drop in the same cycle. No partial write is completed after the reset is released.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined:
  - Adds output instret (32 bits), which increments on every transition into FETCH from MEMWB, MEMWRITE (with mem_ready), ALUWB or BRANCH.
  - Adds output cycles (32 bits), which increments every clock.
  - Both reset to 0, wrap modulo 2^32, and do not count illegal or timed-out instructions.
- When undefined: neither port exists and the FSM behaviour is identical.

Test Plan:
- Reset and fetch: reset_n low, then release; mem_ready held high; op=0110011.
  -> mem_req=0 during reset, then FETCH (ir_write=1), DECODE, EXECR (alu_op=10), ALUWB (reg_write=1), FETCH: 4 cycles per add.
- Load with wait states: op=0000011, mem_ready low for 3 cycles in MEMREAD.
  -> mem_req=1 and adr_src=1 held for 4 cycles, then MEMWB with result_src=01 and reg_write=1. Total 5 + 3 cycles.
- Branch: op=1100011. -> BRANCH state with alu_op=01, branch_en=1 for exactly 1 cycle, then FETCH.
- Jump: op=1101111. -> JAL with pc_update=1 and alu_src_b=10, then ALUWB with reg_write=1.
- Illegal opcode: op=0000000 in DECODE. -> illegal_instr=1 for 1 cycle, next state FETCH, no reg_write or mem_write.
- Timeout: store with mem_ready stuck low, STALL_MAX=15. -> mem_write held for 15 cycles, mem_timeout pulses once, then FETCH. Repeat with mem_ready rising on cycle 15 -> no pulse.
